// File: rtl/i2c_init_sequencer.sv
// Plays a table of I2C register writes through the Avalon I2C master's 8-bit
// register port after reset, reporting done or a latched error code/index.
module i2c_init_sequencer #(
    parameter logic [15:0] PRESCALE    = 16'd199,
    parameter int          NUM_ENTRIES = 16,
    parameter int          IDX_W       = 4,
    parameter int          POLL_LIMIT  = 65535
) (
    input  logic             csi_clk,
    input  logic             csi_reset_n,
    input  logic             start,
    output logic [2:0]       avm_address,
    output logic [7:0]       avm_writedata,
    input  logic [7:0]       avm_readdata,
    output logic             avm_read,
    output logic             avm_write,
    input  logic             avm_waitrequest,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [23:0]      tbl_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [IDX_W-1:0] err_index
);

    localparam int               PCW       = $clog2(POLL_LIMIT + 1);
    localparam logic [PCW-1:0]   LAST_POLL = PCW'(POLL_LIMIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [7:0]       SR_RXACK  = 8'h80;
    localparam logic [7:0]       SR_BUSY   = 8'h40;
    localparam logic [7:0]       SR_AL     = 8'h20;
    localparam logic [7:0]       SR_TIP    = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_PRL, S_CFG_PRH, S_CFG_EN, S_TXR, S_CR, S_POLL,
        S_ABT_CR, S_ABT_POLL, S_DONE, S_ERR
    } state_t;

    state_t           r_state, w_state;
    logic [1:0]       r_phase, w_phase;
    logic [IDX_W-1:0] r_idx, w_idx, r_err_idx, w_err_idx;
    logic [PCW-1:0]   r_poll, w_poll;
    logic             r_read, w_read, r_write, w_write;
    logic [2:0]       r_addr, w_addr;
    logic [7:0]       r_wdata, w_wdata;
    logic             r_busy, w_busy, r_done, w_done, r_error, w_error;
    logic [1:0]       r_code, w_code;

    logic       w_bus_idle, w_acc_done, w_tip, w_al, w_rxack, w_sr_busy;
    logic [7:0] w_txr_byte, w_cr_byte;

    assign w_bus_idle = ~r_read & ~r_write;
    assign w_acc_done = (r_read | r_write) & ~avm_waitrequest;
    assign w_tip      = |(avm_readdata & SR_TIP);
    assign w_al       = |(avm_readdata & SR_AL);
    assign w_rxack    = |(avm_readdata & SR_RXACK);
    assign w_sr_busy  = |(avm_readdata & SR_BUSY);

    // The R/W bit of the address byte is forced to write regardless of table contents.
    always_comb begin
        case (r_phase)
            2'd0:    begin w_txr_byte = tbl_data[23:16] & 8'hFE; w_cr_byte = 8'h90; end
            2'd1:    begin w_txr_byte = tbl_data[15:8];          w_cr_byte = 8'h10; end
            default: begin w_txr_byte = tbl_data[7:0];           w_cr_byte = 8'h50; end
        endcase
    end

    always_comb begin
        w_state   = r_state;
        w_phase   = r_phase;
        w_idx     = r_idx;
        w_err_idx = r_err_idx;
        w_poll    = r_poll;
        w_read    = r_read;
        w_write   = r_write;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_busy    = r_busy;
        w_done    = r_done;
        w_error   = r_error;
        w_code    = r_code;

        // Every access state raises its strobe from an idle bus and drops it on completion,
        // which guarantees the idle cycle between accesses.
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state = S_CFG_PRL;
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_error = 1'b0;
                    w_code  = 2'b00;
                    w_idx   = '0;
                    w_phase = 2'd0;
                end
            end
            S_CFG_PRL: begin
                if (w_bus_idle) begin
                    w_write = 1'b1; w_addr = 3'd0; w_wdata = PRESCALE[7:0];
                end else if (w_acc_done) begin
                    w_write = 1'b0; w_state = S_CFG_PRH;
                end
            end
            S_CFG_PRH: begin
                if (w_bus_idle) begin
                    w_write = 1'b1; w_addr = 3'd1; w_wdata = PRESCALE[15:8];
                end else if (w_acc_done) begin
                    w_write = 1'b0; w_state = S_CFG_EN;
                end
            end
            S_CFG_EN: begin
                if (w_bus_idle) begin
                    w_write = 1'b1; w_addr = 3'd2; w_wdata = 8'h80;
                end else if (w_acc_done) begin
                    w_write = 1'b0; w_state = S_TXR;
                end
            end
            S_TXR: begin
                if (w_bus_idle) begin
                    w_write = 1'b1; w_addr = 3'd3; w_wdata = w_txr_byte;
                end else if (w_acc_done) begin
                    w_write = 1'b0; w_state = S_CR;
                end
            end
            S_CR: begin
                if (w_bus_idle) begin
                    w_write = 1'b1; w_addr = 3'd4; w_wdata = w_cr_byte;
                end else if (w_acc_done) begin
                    w_write = 1'b0; w_poll = '0; w_state = S_POLL;
                end
            end
            S_POLL: begin
                if (w_bus_idle) begin
                    w_read = 1'b1; w_addr = 3'd4;
                end else if (w_acc_done) begin
                    w_read = 1'b0;
                    if (w_tip) begin
                        if (r_poll == LAST_POLL) begin
                            w_code = 2'b11; w_err_idx = r_idx; w_state = S_ABT_CR;
                        end else begin
                            w_poll = r_poll + 1'b1;
                        end
                    end else if (w_al) begin
                        // Arbitration lost: the bus is no longer ours, so no STOP.
                        w_code = 2'b10; w_err_idx = r_idx;
                        w_error = 1'b1; w_busy = 1'b0; w_state = S_ERR;
                    end else if (w_rxack) begin
                        w_code = 2'b01; w_err_idx = r_idx; w_state = S_ABT_CR;
                    end else if (r_phase != 2'd2) begin
                        w_phase = r_phase + 1'b1; w_state = S_TXR;
                    end else if (r_idx == LAST_IDX) begin
                        w_done = 1'b1; w_busy = 1'b0; w_state = S_DONE;
                    end else begin
                        w_idx = r_idx + 1'b1; w_phase = 2'd0; w_state = S_TXR;
                    end
                end
            end
            S_ABT_CR: begin
                if (w_bus_idle) begin
                    w_write = 1'b1; w_addr = 3'd4; w_wdata = 8'h40;
                end else if (w_acc_done) begin
                    w_write = 1'b0; w_poll = '0; w_state = S_ABT_POLL;
                end
            end
            S_ABT_POLL: begin
                if (w_bus_idle) begin
                    w_read = 1'b1; w_addr = 3'd4;
                end else if (w_acc_done) begin
                    w_read = 1'b0;
                    if (!w_sr_busy || r_poll == LAST_POLL) begin
                        w_error = 1'b1; w_busy = 1'b0; w_state = S_ERR;
                    end else begin
                        w_poll = r_poll + 1'b1;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            r_state   <= S_IDLE;
            r_phase   <= 2'd0;
            r_idx     <= '0;
            r_err_idx <= '0;
            r_poll    <= '0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= 3'd0;
            r_wdata   <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_code    <= 2'b00;
        end else begin
            r_state   <= w_state;
            r_phase   <= w_phase;
            r_idx     <= w_idx;
            r_err_idx <= w_err_idx;
            r_poll    <= w_poll;
            r_read    <= w_read;
            r_write   <= w_write;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_error   <= w_error;
            r_code    <= w_code;
        end
    end

    assign avm_address   = r_addr;
    assign avm_writedata = r_wdata;
    assign avm_read      = r_read;
    assign avm_write     = r_write;
    assign tbl_index     = r_idx;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign err_code      = r_code;
    assign err_index     = r_err_idx;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench: a small I2C-controller register model answers the sequencer,
// records its write trace and watches the Avalon handshake rules.
module tb_i2c_init_sequencer;

    localparam int IDX_W = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             clr = 1'b0;
    logic [2:0]       avm_address;
    logic [7:0]       avm_writedata;
    logic [7:0]       avm_readdata;
    logic             avm_read, avm_write, avm_waitrequest;
    logic [IDX_W-1:0] tbl_index, err_index;
    logic [23:0]      tbl_data;
    logic             busy, done, error;
    logic [1:0]       err_code;

    int total = 0;
    int bad = 0;
    int mode = 0;
    logic stall_mode = 1'b0;

    int         wcnt = 0;
    int         rd_cnt = 0;
    int         cr_cnt = 0;
    int         abort_reads = 0;
    int         tr_n = 0;
    int         stall_viol = 0;
    int         proto_viol = 0;
    int         cur_wait;
    logic [7:0] last_cr = 8'h00;
    logic       prev_stall = 1'b0;
    logic       prev_comp = 1'b0;
    logic [12:0] prev_bus = '0;
    logic [10:0] tr [0:63];
    logic [10:0] exp_tr [0:63];
    int          exp_n = 0;

    i2c_init_sequencer #(
        .PRESCALE(16'd199), .NUM_ENTRIES(2), .IDX_W(IDX_W), .POLL_LIMIT(8)
    ) dut (
        .csi_clk(clk), .csi_reset_n(rst_n), .start(start),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_read(avm_read), .avm_write(avm_write),
        .avm_waitrequest(avm_waitrequest), .tbl_index(tbl_index), .tbl_data(tbl_data),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index)
    );

    always #5 clk = ~clk;

    assign tbl_data = (tbl_index == 1'b0) ? 24'h34053C : 24'h34067F;
    assign cur_wait = stall_mode ? 5 : (avm_read ? 1 : 0);
    assign avm_waitrequest = (avm_read || avm_write) && (wcnt < cur_wait);

    // SR model: first read after each CR write shows TIP; mode picks the fault injected.
    always_comb begin
        if (last_cr == 8'h40)                 avm_readdata = (rd_cnt == 0) ? 8'h40 : 8'h00;
        else if (mode == 3)                   avm_readdata = 8'h02;
        else if (rd_cnt == 0)                 avm_readdata = 8'h42;
        else if (mode == 1 && cr_cnt == 4)    avm_readdata = 8'h80;
        else if (mode == 2 && cr_cnt == 2)    avm_readdata = 8'h20;
        else                                  avm_readdata = 8'h00;
    end

    always @(posedge clk) begin
        if (clr) begin
            wcnt <= 0; rd_cnt <= 0; cr_cnt <= 0; abort_reads <= 0; tr_n <= 0;
            stall_viol <= 0; proto_viol <= 0; last_cr <= 8'h00;
            prev_stall <= 1'b0; prev_comp <= 1'b0;
        end else if (rst_n) begin
            prev_stall <= (avm_read || avm_write) && avm_waitrequest;
            prev_comp  <= (avm_read || avm_write) && !avm_waitrequest;
            prev_bus   <= {avm_read, avm_write, avm_address, avm_writedata};
            if (prev_stall && ({avm_read, avm_write, avm_address, avm_writedata} != prev_bus))
                stall_viol <= stall_viol + 1;
            proto_viol <= proto_viol + ((avm_read && avm_write) ? 1 : 0)
                                     + ((prev_comp && (avm_read || avm_write)) ? 1 : 0);
            if ((avm_read || avm_write) && avm_waitrequest) wcnt <= wcnt + 1;
            else                                            wcnt <= 0;
            if (avm_write && !avm_waitrequest) begin
                if (tr_n < 64) tr[tr_n] <= {avm_address, avm_writedata};
                tr_n <= tr_n + 1;
                if (avm_address == 3'd4) begin
                    last_cr <= avm_writedata;
                    rd_cnt  <= 0;
                    cr_cnt  <= cr_cnt + 1;
                    if (avm_writedata == 8'h40) abort_reads <= rd_cnt;
                end
            end
            if (avm_read && !avm_waitrequest) rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_push(input logic [2:0] a, input logic [7:0] d);
        exp_tr[exp_n] = {a, d};
        exp_n++;
    endtask

    task automatic exp_cfg();
        exp_n = 0;
        exp_push(3'd0, 8'hC7); exp_push(3'd1, 8'h00); exp_push(3'd2, 8'h80);
    endtask

    task automatic exp_entry(input logic [7:0] dev, input logic [7:0] rg, input logic [7:0] dt);
        exp_push(3'd3, dev); exp_push(3'd4, 8'h90);
        exp_push(3'd3, rg);  exp_push(3'd4, 8'h10);
        exp_push(3'd3, dt);  exp_push(3'd4, 8'h50);
    endtask

    task automatic exp_full();
        exp_cfg();
        exp_entry(8'h34, 8'h05, 8'h3C);
        exp_entry(8'h34, 8'h06, 8'h7F);
    endtask

    task automatic check_trace(input string tag);
        chk({tag, "_nwr"}, tr_n, exp_n);
        for (int i = 0; i < exp_n && i < 64; i++)
            chk($sformatf("%s_wr%0d", tag, i), tr[i], exp_tr[i]);
        chk({tag, "_proto"}, proto_viol, 0);
    endtask

    task automatic clear_model();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || error) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, done || error, 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {avm_read, avm_write, avm_address, avm_writedata, tbl_index,
                              busy, done, error, err_code, err_index}, 0);
        rst_n = 1'b1;

        clear_model(); mode = 0;
        pulse_start();
        chk("s1_busy", busy, 1);
        wait_end("s1");
        chk("s1_done", done, 1); chk("s1_busy_end", busy, 0); chk("s1_error", error, 0);
        chk("s1_index", tbl_index, 1);
        exp_full(); check_trace("s1");

        clear_model(); mode = 1;
        pulse_start(); wait_end("s2");
        chk("s2_error", error, 1); chk("s2_code", err_code, 2'b01);
        chk("s2_eidx", err_index, 1); chk("s2_done", done, 0); chk("s2_busy", busy, 0);
        exp_cfg(); exp_entry(8'h34, 8'h05, 8'h3C);
        exp_push(3'd3, 8'h34); exp_push(3'd4, 8'h90); exp_push(3'd4, 8'h40);
        check_trace("s2");

        clear_model(); mode = 2;
        pulse_start(); wait_end("s3");
        chk("s3_error", error, 1); chk("s3_code", err_code, 2'b10); chk("s3_eidx", err_index, 0);
        exp_cfg();
        exp_push(3'd3, 8'h34); exp_push(3'd4, 8'h90); exp_push(3'd3, 8'h05); exp_push(3'd4, 8'h10);
        check_trace("s3");

        clear_model(); mode = 3;
        pulse_start(); wait_end("s4");
        chk("s4_error", error, 1); chk("s4_code", err_code, 2'b11); chk("s4_eidx", err_index, 0);
        chk("s4_sr_reads", abort_reads, 8);
        exp_cfg(); exp_push(3'd3, 8'h34); exp_push(3'd4, 8'h90); exp_push(3'd4, 8'h40);
        check_trace("s4");

        clear_model(); mode = 0; stall_mode = 1'b1;
        pulse_start(); wait_end("s5");
        chk("s5_done", done, 1); chk("s5_error", error, 0);
        chk("s5_stall_stable", stall_viol, 0);
        exp_full(); check_trace("s5");
        stall_mode = 1'b0;

        clear_model(); mode = 0;
        pulse_start();
        repeat (10) @(negedge clk);
        chk("s6_busy_before", busy, 1);
        pulse_start();
        n = 0;
        while (tr_n < 6 && n < 2000) begin @(negedge clk); n++; end
        n = 0;
        while (!(avm_write && avm_address == 3'd4) && n < 100) begin @(negedge clk); n++; end
        chk("s6_nwr_prefix", tr_n, 6);
        exp_full();
        for (int i = 0; i < 6; i++) chk($sformatf("s6_prefix%0d", i), tr[i], exp_tr[i]);
        chk("s6_cr_strobe", {avm_write, avm_writedata}, 9'h110);
        #1 rst_n = 1'b0;
        #1 chk("s6_reset_outputs", {avm_read, avm_write, avm_address, avm_writedata, tbl_index,
                                    busy, done, error, err_code, err_index}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        pulse_start(); wait_end("s6");
        chk("s6_done", done, 1); chk("s6_error", error, 0);
        check_trace("s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Avalon-MM master that drives the 8-bit register port of the Avalon I2C master controller and plays back a table of I2C register writes.
- Typical use: configuring board peripherals (codecs, clock synthesisers, HDMI transmitters) after reset without CPU involvement.
- Sits directly upstream of the I2C controller's Avalon slave port. A fabric mux hands the port to the CPU once done or error is asserted.

Parameters:
- PRESCALE, 16'd199, clock prescale value written to PRERlo/PRERhi (100 MHz core clock -> 100 kHz SCL).
- NUM_ENTRIES, 16, number of table entries played back (1..2^IDX_W).
- IDX_W, 4, width of table index.
- POLL_LIMIT, 65535, maximum status reads per transfer before timeout.

Ports:
- csi_clk  in  1  core clock
- csi_reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a sequence when idle
- avm_address  out  3  controller register address
- avm_writedata  out  8  write data
- avm_readdata  in  8  read data
- avm_read  out  1  read strobe
- avm_write  out  1  write strobe
- avm_waitrequest  in  1  slave stall
- tbl_index  out  IDX_W  current table entry
- tbl_data  in  24  {dev_addr[6:0], 1'b0, reg[7:0], data[7:0]}, combinational from tbl_index
- busy  out  1  sequence in progress
- done  out  1  sticky; sequence completed successfully
- error  out  1  sticky; sequence aborted
- err_code  out  2  01 NACK, 10 arbitration lost, 11 poll timeout
- err_index  out  IDX_W  entry that failed

Behaviour:
- Reset (async assert, sync deassert): state IDLE; avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, tbl_index=0, busy=0, done=0, error=0, err_code=0, err_index=0.
- Controller register map (word addresses):
  - 0 PRERlo, 1 PRERhi, 2 CTR (EN=bit7), 3 TXR, 4 CR (write) / SR (read).
  - CR bits: STA=7, STO=6, WR=4.
  - SR bits: RxACK=7, BUSY=6, AL=5, TIP=1.
- Bus rules:
  - Exactly one of avm_read/avm_write is high per access.
  - avm_address, avm_writedata and the strobe are held stable until the cycle with avm_waitrequest=0; that cycle completes the access.
  - Read data is captured in the completing cycle.
  - Strobes drop the cycle after completion. No back-to-back accesses: at least one idle cycle between accesses.
- Start handling:
  - start is accepted only in IDLE, DONE or ERR.
  - Acceptance clears done, error and err_code, sets busy, and sets tbl_index=0.
  - start while busy is ignored.
- Configuration states:
  - CFG_PRL: write PRESCALE[7:0] to addr 0.
  - CFG_PRH: write PRESCALE[15:8] to addr 1.
  - CFG_EN: write 8'h80 to addr 2.
- Per entry, three phases:
  - Phase A: TXR <- {dev_addr,0}; CR <- 8'h90 (STA|WR).
  - Phase B: TXR <- reg; CR <- 8'h10 (WR).
  - Phase C: TXR <- data; CR <- 8'h50 (STO|WR).
- POLL after each CR write:
  - Read SR repeatedly, one idle cycle between reads, until TIP=0. Poll counter resets per transfer.
  - Then CHECK:
    - AL=1 -> error code 10, go to ERR directly. No STOP is issued; the controller has lost the bus.
    - else RxACK=1 -> error code 01, go to ABORT.
    - else go to the next phase.
  - POLL_LIMIT reads with TIP still 1 -> error code 11, go to ABORT.
- ABORT: write CR <- 8'h40 (STO), then poll SR until BUSY=0 (bounded by POLL_LIMIT; on overrun go to ERR anyway), then ERR.
- After phase C passes CHECK:
  - If tbl_index == NUM_ENTRIES-1, go to DONE: busy=0, done=1.
  - Otherwise increment tbl_index and start phase A.
  - tbl_index never wraps.
- ERR: busy=0, error=1, err_code latched, err_index = tbl_index at failure.
- Reset mid-sequence: strobes drop immediately (async). The partial I2C transaction is abandoned; recovery is the controller's reset.
- Latency: each register write costs ≥2 cycles (strobe + idle). Each SR read costs ≥3 cycles against the controller's one-cycle read wait.

Test Plan:
- Reset then start, NUM_ENTRIES=2, ACK slave model, table {0x1A,0x05,0x3C},{0x1A,0x06,0x7F}, PRESCALE=199 -> write trace 0<-C7, 1<-00, 2<-80, then 3<-34, 4<-90, 3<-05, 4<-10, 3<-3C, 4<-50, then the same for entry 1; done=1, busy=0, error=0.
- Slave NACKs the address of entry 1 -> after 4<-90 poll, CR write 4<-40, poll to BUSY=0; error=1, err_code=01, err_index=1, done=0.
- SR returns AL=1 after an entry 0 phase B transfer -> no STO write; error=1, err_code=10, err_index=0.
- SR TIP stuck at 1 with POLL_LIMIT=8 -> exactly 8 SR reads, then STO abort; err_code=11.
- avm_waitrequest held high for 5 cycles on every access -> address, data and strobe constant throughout each stall; trace identical to scenario 1.
- start pulsed while busy, and csi_reset_n asserted mid-phase B -> start ignored; on reset all outputs return to reset values in the same cycle; a subsequent start replays from tbl_index=0.
